// File: rtl/seq_divider_module_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and the FSM state encoding.
package seq_divider_module_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2,
    ACK    = 2'd3
  } state_t;

endpackage

// File: rtl/div_step_module.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and restore on borrow.
module div_step_module #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_remainder,
  input  logic             i_dividend_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_remainder,
  output logic             o_quotient_bit
);

  // One extra bit above the shifted remainder acts as the borrow/sign bit.
  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_trial;

  assign w_shifted      = {i_remainder, i_dividend_msb};
  assign w_trial        = w_shifted - {2'b00, i_divisor};
  assign o_quotient_bit = ~w_trial[WIDTH+1];
  assign o_remainder    = w_trial[WIDTH+1] ? w_shifted[WIDTH:0] : w_trial[WIDTH:0];

endmodule

// File: rtl/seq_divider_module.sv
// Multi-cycle unsigned restoring divider: IDLE -> CALC (WIDTH steps) ->
// FINISH (load results, pulse Done_Sig) -> ACK -> IDLE.
module seq_divider_module
  import seq_divider_module_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             Start_Sig,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero,
  output logic             Busy,
  output logic             Done_Sig
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_zero;
  logic             r_done;
  logic [WIDTH:0]   w_next_rem;
  logic             w_q_bit;
  logic             w_last;

  div_step_module #(.WIDTH(WIDTH)) u_step (
    .i_remainder    (r_rem),
    .i_dividend_msb (r_dividend[WIDTH-1]),
    .i_divisor      (r_divisor),
    .o_remainder    (w_next_rem),
    .o_quotient_bit (w_q_bit)
  );

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (Start_Sig) w_next_state = CALC;
      CALC:    if (w_last)    w_next_state = FINISH;
      FINISH:  w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: every register here is cleared by the async reset, so an aborted
  // division leaves no stale operands or partial results behind.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start_Sig) begin
            r_dividend <= A;
            r_divisor  <= B;
            r_rem      <= '0;
            r_count    <= '0;
          end
        end
        CALC: begin
          // The dividend register doubles as the quotient shift register.
          r_rem      <= w_next_rem;
          r_dividend <= {r_dividend[WIDTH-2:0], w_q_bit};
          r_count    <= r_count + CNT_W'(1);
        end
        FINISH: begin
          r_quotient  <= r_dividend;
          r_remainder <= r_rem[WIDTH-1:0];
          r_div_zero  <= (r_divisor == '0);
          r_done      <= 1'b1;
        end
        ACK:     r_done <= 1'b0;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign Quotient  = r_quotient;
  assign Remainder = r_remainder;
  assign DivZero   = r_div_zero;
  assign Done_Sig  = r_done;
  // NOTE: decoded straight from the state register, no extra flop.
  assign Busy      = (r_state != IDLE);

endmodule

// File: doc/seq_divider_module.md
SEQ_DIVIDER_MODULE -- requirements
Module: seq_divider_module

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; only 8 is required to be supported.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 Start_Sig  input  1  request; sampled only in IDLE.
REQ-005 A  input  WIDTH  dividend, unsigned.
REQ-006 B  input  WIDTH  divisor, unsigned.
REQ-007 Quotient  output  WIDTH  registered quotient.
REQ-008 Remainder  output  WIDTH  registered remainder.
REQ-009 DivZero  output  1  registered flag, set when the captured divisor was 0.
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 Done_Sig  output  1  one-cycle completion pulse.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FINISH and ACK.
REQ-013 IDLE: on an edge with Start_Sig=1, the block SHALL capture A and B into internal registers, clear the partial remainder (WIDTH+1 bits), clear the iteration counter and go to CALC; otherwise it SHALL stay in IDLE.
REQ-014 CALC: each edge SHALL perform one restoring step.
  - shift {remainder, dividend} left by 1
  - trial = remainder - divisor (WIDTH+1 bits)
  - if trial is non-negative (MSB=0): keep trial, quotient LSB=1
  - else: keep remainder, quotient LSB=0
REQ-015 CALC SHALL last exactly WIDTH edges; the counter SHALL go 0..WIDTH-1, and the edge at WIDTH-1 SHALL move the FSM to FINISH.
REQ-016 FINISH: one edge SHALL load Quotient, Remainder and DivZero and set Done_Sig=1, then go to ACK.
REQ-017 ACK: one edge SHALL clear Done_Sig and return to IDLE.
REQ-018 Latency: Start accepted at edge t SHALL give Done_Sig=1 for exactly the cycle between edges t+WIDTH+1 and t+WIDTH+2; the next Start is acceptable at edge t+WIDTH+3.
REQ-019 Start_Sig asserted outside IDLE SHALL be ignored, with no queuing.
REQ-020 A or B changing after capture SHALL NOT affect the result in progress.
REQ-021 Divisor 0: latency SHALL be unchanged; results SHALL be Quotient=all ones, Remainder=captured A, DivZero=1.
REQ-022 Divisor non-zero: DivZero SHALL be 0 and Quotient*B+Remainder SHALL equal A, with Remainder<B.
REQ-023 Quotient, Remainder and DivZero SHALL hold their values until the next FINISH.
REQ-024 Busy SHALL be combinational from the state register only.

Reset
REQ-025 While RSTn=0, the state SHALL be IDLE.
REQ-026 While RSTn=0, Quotient, Remainder, DivZero, Done_Sig and Busy SHALL be 0.
REQ-027 While RSTn=0, all internal operand, remainder and counter registers SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL abort the division with no Done_Sig pulse.
REQ-029 After reset release, the first edge SHALL behave as IDLE.

Structure
REQ-030 A shared package SHALL hold the WIDTH default and the state encodings (IDLE=0, CALC=1, FINISH=2, ACK=3, 2 bits).
REQ-031 One combinational sub-module, div_step_module, SHALL implement a single shift/subtract/restore step (inputs: remainder, dividend MSB, divisor; outputs: next remainder, quotient bit).
REQ-032 The top SHALL hold the FSM and all registers.

Verification
REQ-033 A=100, B=7, Start for one cycle -> Done_Sig pulse exactly 10 cycles after the Start edge; Q=14, R=2, DivZero=0, Busy high for 10 cycles.
REQ-034 A=255, B=1 -> Q=255, R=0; then A=5, B=9 -> Q=0, R=5.
REQ-035 A=200, B=0 -> Q=8'hFF, R=200, DivZero=1, same latency.
REQ-036 Start held high continuously with A=50, B=5, then A changed to 99 during CALC -> first result Q=10, R=0; the next capture happens 11 cycles after the first.
REQ-037 RSTn pulsed low during CALC (iteration 4) -> all outputs 0 immediately, no Done_Sig; a new Start with A=9, B=4 then gives Q=2, R=1.
REQ-038 Randomised sweep of all A, B pairs against a reference model -> Q*B+R=A and R<B for every B≠0.
